sync_count_lock: RTL and testbench

//  Parametrised sync-to-counter aligner for the VGA pipeline. Delays incoming

---
 rtl/sync_count_lock.sv | 181 ++++++++++++++++++
 tb/tb_sync_count_lock.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_count_lock.sv
// rtl/sync_count_lock.sv - sync delay line with aligned col/row counters and frame lock monitor
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_hsync        raw horizontal sync
//   i_vsync        raw vertical sync
//   o_hsync        i_hsync delayed DELAY cycles
//   o_vsync        i_vsync delayed DELAY cycles
//   o_col_count    column counter aligned to o_hsync/o_vsync
//   o_row_count    row counter aligned to o_hsync/o_vsync
//   o_active       col < ACTIVE_COLS && row < ACTIVE_ROWS
//   o_frame_start  1-cycle pulse when counts reload to (0,0)
//   o_locked       frame timing matches TOTAL_COLS x TOTAL_ROWS
//   o_frame_err    1-cycle pulse on short, long or missing frame
module sync_count_lock #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CNT_W       = 10,
  parameter int DELAY       = 1,
  parameter int VS_RISE     = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CNT_W-1:0] o_col_count,
  output logic [CNT_W-1:0] o_row_count,
  output logic             o_active,
  output logic             o_frame_start,
  output logic             o_locked,
  output logic             o_frame_err
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   ACT_COLS = (CNT_W + 1)'(ACTIVE_COLS);
  localparam logic [CNT_W:0]   ACT_ROWS = (CNT_W + 1)'(ACTIVE_ROWS);
  localparam logic [3:0]       LOCK_LIM = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNSEEN,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  // Stage k of the delay line is bit k of *_s; bit 0 is the raw input.
  logic [DELAY-1:0] vs_q;
  logic [DELAY-1:0] hs_q;
  logic [DELAY:0]   vs_s;
  logic [DELAY:0]   hs_s;

  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] col_nx;
  logic [CNT_W-1:0] row_nx;

  state_t     state_q;
  logic [3:0] match_q;

  logic fs;
  logic col_last;
  logic row_last;
  logic term;

  assign vs_s = {vs_q, i_vsync};
  assign hs_s = {hs_q, i_hsync};

  assign o_vsync     = vs_q[DELAY-1];
  assign o_hsync     = hs_q[DELAY-1];
  assign o_col_count = col_q;
  assign o_row_count = row_q;

  // Edge is detected one stage ahead of the output so that the counters
  // reload on the same clock edge that o_vsync takes its new level.
  always_comb begin
    fs = 1'b0;
    if (VS_RISE != 0) begin
      fs = vs_s[DELAY-1] & ~vs_s[DELAY];
    end else begin
      fs = ~vs_s[DELAY-1] & vs_s[DELAY];
    end
  end

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign term     = col_last & row_last;

  always_comb begin
    col_nx = col_q + CNT_ONE;
    row_nx = row_q;
    if (fs) begin
      col_nx = '0;
      row_nx = '0;
    end else if (col_last) begin
      col_nx = '0;
      row_nx = row_last ? '0 : (row_q + CNT_ONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_q <= '0;
      hs_q <= '0;
    end else begin
      vs_q <= vs_s[DELAY-1:0];
      hs_q <= hs_s[DELAY-1:0];
    end
  end

  // o_active and o_frame_start are registered from the next-count values so
  // they line up with the counter registers without extra latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      col_q         <= col_nx;
      row_q         <= row_nx;
      o_active      <= ({1'b0, col_nx} < ACT_COLS) && ({1'b0, row_nx} < ACT_ROWS);
      o_frame_start <= fs;
    end
  end

  // A frame start that lands exactly on the last count is a good frame; a
  // frame start anywhere else, or a wrap with no frame start, is a bad one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_UNSEEN;
      match_q     <= '0;
      o_locked    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      case (state_q)
        ST_UNSEEN: begin
          if (fs) begin
            state_q <= ST_ACQUIRE;
            match_q <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (fs && term) begin
            if (match_q == LOCK_LIM - 4'd1) begin
              state_q  <= ST_LOCKED;
              match_q  <= LOCK_LIM;
              o_locked <= 1'b1;
            end else begin
              match_q <= match_q + 4'd1;
            end
          end else if (fs || term) begin
            match_q     <= '0;
            o_frame_err <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!(fs && term) && (fs || term)) begin
            state_q     <= ST_ACQUIRE;
            match_q     <= '0;
            o_locked    <= 1'b0;
            o_frame_err <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_UNSEEN;
          match_q  <= '0;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_count_lock.sv
// tb/tb_sync_count_lock.sv - bench for sync_count_lock on an 8x5 timing (40-cycle frame)
module tb_sync_count_lock;

  logic clk = 1'b0;
  logic rst_n;
  logic hsync;
  logic vsync;

  logic       a_hsync, a_vsync, a_active, a_fs, a_locked, a_err;
  logic [3:0] a_col, a_row;
  logic       b_hsync, b_vsync, b_active, b_fs, b_locked, b_err;
  logic [3:0] b_col, b_row;

  always #5 clk = ~clk;

  sync_count_lock #(
    .TOTAL_COLS(8), .TOTAL_ROWS(5), .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
    .CNT_W(4), .DELAY(1), .VS_RISE(1), .LOCK_FRAMES(2)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .o_col_count(a_col), .o_row_count(a_row),
    .o_active(a_active), .o_frame_start(a_fs), .o_locked(a_locked), .o_frame_err(a_err)
  );

  sync_count_lock #(
    .TOTAL_COLS(8), .TOTAL_ROWS(5), .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
    .CNT_W(4), .DELAY(3), .VS_RISE(0), .LOCK_FRAMES(2)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .o_col_count(b_col), .o_row_count(b_row),
    .o_active(b_active), .o_frame_start(b_fs), .o_locked(b_locked), .o_frame_err(b_err)
  );

  typedef struct {
    logic       h;
    logic       v;
    logic [3:0] col;
    logic [3:0] row;
    logic       act;
    logic       fs;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl[12];

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  // Newest input in bit 0; bit 2 is what the DELAY=3 instance shows now.
  logic [2:0] vhist = '0;
  logic [2:0] hhist = '0;

  logic       b_cap_vs, b_cap_fs;
  logic [3:0] b_cap_col, b_cap_row;

  logic [3:0] fc, fr;
  logic       ffs, flk, fer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v);
    hsync = h;
    vsync = v;
    vhist = {vhist[1:0], v};
    hhist = {hhist[1:0], h};
    @(posedge clk);
    #1;
    if (a_err) err_pulses++;
    chk("b_vsync_delay3", b_vsync, vhist[2]);
    chk("b_hsync_delay3", b_hsync, hhist[2]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    vhist = '0;
    hhist = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One vsync period of len cycles: vsync high for two cycles, then low.
  // Returns the A-instance state seen in the frame-start cycle.
  task automatic vframe(input int len, output logic [3:0] c, output logic [3:0] r,
                        output logic fsv, output logic lk, output logic er);
    for (int i = 0; i < len; i++) begin
      tick(((i % 8) < 2), (i < 2));
      if (i == 0) begin
        c = a_col; r = a_row; fsv = a_fs; lk = a_locked; er = a_err;
      end
      if (i == 4) begin
        b_cap_vs = b_vsync; b_cap_fs = b_fs; b_cap_col = b_col; b_cap_row = b_row;
      end
    end
  endtask

  task automatic chk_frame(input string name, input logic lk_exp, input logic er_exp);
    chk({name, "_col"}, fc, 0);
    chk({name, "_row"}, fr, 0);
    chk({name, "_fs"}, ffs, 1);
    chk({name, "_locked"}, flk, lk_exp);
    chk({name, "_err"}, fer, er_exp);
  endtask

  initial begin
    //            h     v     col    row    act   fs    hs    vs
    tbl[0]  = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col", a_col, 0);
    chk("rst_row", a_row, 0);
    chk("rst_active", a_active, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_err", a_err, 0);
    chk("rst_vsync", a_vsync, 0);
    chk("rst_b_col", b_col, 0);
    rst_n = 1'b1;

    // Free-running count after reset, then a DELAY=1 vsync rise.
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].h, tbl[i].v);
      chk($sformatf("vec%0d_col", i), a_col, tbl[i].col);
      chk($sformatf("vec%0d_row", i), a_row, tbl[i].row);
      chk($sformatf("vec%0d_active", i), a_active, tbl[i].act);
      chk($sformatf("vec%0d_fs", i), a_fs, tbl[i].fs);
      chk($sformatf("vec%0d_hsync", i), a_hsync, tbl[i].hs);
      chk($sformatf("vec%0d_vsync", i), a_vsync, tbl[i].vs);
    end

    // No further syncs: count runs to (7,4) and wraps, flagged as a bad frame.
    repeat (37) tick(1'b0, 1'b0);
    chk("wrap_pre_col", a_col, 7);
    chk("wrap_pre_row", a_row, 4);
    tick(1'b0, 1'b0);
    chk("wrap_col", a_col, 0);
    chk("wrap_row", a_row, 0);
    chk("wrap_err", a_err, 1);
    chk("wrap_fs", a_fs, 0);
    chk("wrap_err_pulses", err_pulses, 1);

    // Lock acquisition with correct 40-cycle frames.
    do_reset();
    err_pulses = 0;
    repeat (5) tick(1'b0, 1'b0);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f1", 1'b0, 1'b0);
    chk("b_fall_vsync", b_cap_vs, 0);
    chk("b_fall_col", b_cap_col, 0);
    chk("b_fall_row", b_cap_row, 0);
    chk("b_fall_fs", b_cap_fs, 1);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f2", 1'b0, 1'b0);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f3", 1'b1, 1'b0);
    chk("lock_err_pulses", err_pulses, 0);

    // One short frame drops lock; two good frames regain it.
    vframe(39, fc, fr, ffs, flk, fer);
    chk_frame("f4", 1'b1, 1'b0);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f5_short", 1'b0, 1'b1);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f6", 1'b0, 1'b0);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("f7", 1'b1, 1'b0);
    chk("short_err_pulses", err_pulses, 1);

    // vsync removed while locked.
    tick(1'b0, 1'b0);
    chk("lost_err", a_err, 1);
    chk("lost_locked", a_locked, 0);
    chk("lost_col", a_col, 0);
    chk("lost_row", a_row, 0);
    repeat (6) tick(1'b0, 1'b0);
    chk("act_6_0_col", a_col, 6);
    chk("act_6_0", a_active, 0);
    repeat (23) tick(1'b0, 1'b0);
    chk("act_5_3_col", a_col, 5);
    chk("act_5_3_row", a_row, 3);
    chk("act_5_3", a_active, 1);
    repeat (3) tick(1'b0, 1'b0);
    chk("act_0_4_row", a_row, 4);
    chk("act_0_4", a_active, 0);

    // Re-lock (first frame start is off-term), then reset mid-frame.
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("r1", 1'b0, 1'b1);
    vframe(40, fc, fr, ffs, flk, fer);
    chk_frame("r2", 1'b0, 1'b0);
    vframe(20, fc, fr, ffs, flk, fer);
    chk_frame("r3", 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("pre_rst_col", a_col, 4);
    chk("pre_rst_row", a_row, 2);
    chk("pre_rst_hsync", a_hsync, 1);
    chk("pre_rst_locked", a_locked, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", a_col, 0);
    chk("mid_rst_row", a_row, 0);
    chk("mid_rst_hsync", a_hsync, 0);
    chk("mid_rst_locked", a_locked, 0);
    chk("mid_rst_active", a_active, 0);
    chk("mid_rst_b_col", b_col, 0);
    chk("mid_rst_b_hsync", b_hsync, 0);
    hsync = 1'b0;
    vsync = 1'b0;
    vhist = '0;
    hhist = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    chk("post_rst_col", a_col, 1);
    chk("post_rst_row", a_row, 0);
    chk("post_rst_locked", a_locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
